// File: rtl/aes_comp_pkg.sv
// Shared AES datapath helpers for the column-serial round stages.
//   AES_RED_POLY : low byte of the GF(2^8) reduction polynomial 0x11B
//   col_t        : one 32-bit state column, [31:24]=row0 ... [7:0]=row3
//   xtime8       : multiply a byte by 2 in GF(2^8)
//   mix_col32    : MixColumns applied to a single column
package aes_comp_pkg;

  localparam logic [7:0] AES_RED_POLY = 8'h1B;
  localparam int unsigned NCOL = 4;

  typedef logic [31:0] col_t;

  function automatic logic [7:0] xtime8(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_RED_POLY : 8'h00);
  endfunction

  // 3*a is folded in as xtime8(a) ^ a.
  function automatic col_t mix_col32(input col_t c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] o0, o1, o2, o3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    o0 = xtime8(a0) ^ xtime8(a1) ^ a1 ^ a2 ^ a3;
    o1 = a0 ^ xtime8(a1) ^ xtime8(a2) ^ a2 ^ a3;
    o2 = a0 ^ a1 ^ xtime8(a2) ^ xtime8(a3) ^ a3;
    o3 = xtime8(a0) ^ a0 ^ a1 ^ a2 ^ xtime8(a3);
    return {o0, o1, o2, o3};
  endfunction

endpackage

// File: rtl/aes_mixcol32.sv
// Combinational MixColumns for one 32-bit column.
//   col_i : input column (row0 in the top byte)
//   col_o : mixed column, same byte order
module aes_mixcol32
  import aes_comp_pkg::*;
(
  input  col_t col_i,
  output col_t col_o
);

  assign col_o = mix_col32(col_i);

endmodule

// File: rtl/aes_shiftmix_col32.sv
// Column-serial ShiftRows+MixColumns stage with ping-pong block buffers.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : SubBytes column handshake, in_col plus in_final
//   out_valid/out_ready : AddRoundKey-facing handshake
//   out_col/out_idx     : result column and its index within the block
//   out_final           : result belongs to a final-round (no MixColumns) block
// Parameters: OUT_REG registers the output column, MIX_EN=0 removes MixColumns.
module aes_shiftmix_col32
  import aes_comp_pkg::*;
#(
  parameter bit OUT_REG = 1'b1,
  parameter bit MIX_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_col,
  input  logic        in_final,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_col,
  output logic [1:0]  out_idx,
  output logic        out_final
);

  col_t       bank_q [2][NCOL];
  logic [1:0] full_q, full_d;
  logic [1:0] final_q, final_d;
  logic       wbank_q, wbank_d;
  logic       rbank_q, rbank_d;
  logic [1:0] wcol_q, wcol_d;
  logic [1:0] rcol_q, rcol_d;
  logic       rdy_q;

  logic       wr_en;
  logic       rd_avail;
  logic       rd_take;
  col_t       shifted;
  col_t       mixed;
  col_t       rd_col;
  logic       rd_final;

  // rdy_q keeps in_ready low through reset and for no longer than one edge after it.
  assign in_ready = rdy_q & ~full_q[wbank_q];
  assign wr_en    = in_valid & in_ready;
  assign rd_avail = full_q[rbank_q];
  assign rd_final = final_q[rbank_q];

  // ShiftRows: row r of output column c comes from stored column (c+r) mod 4.
  always_comb begin
    logic [1:0] sidx;
    shifted = '0;
    sidx    = '0;
    for (int r = 0; r < 4; r++) begin
      sidx = rcol_q + 2'(r);
      shifted[31-8*r -: 8] = bank_q[rbank_q][sidx][31-8*r -: 8];
    end
  end

  aes_mixcol32 u_mix (
    .col_i (shifted),
    .col_o (mixed)
  );

  assign rd_col = (rd_final || !MIX_EN) ? shifted : mixed;

  always_comb begin
    full_d  = full_q;
    final_d = final_q;
    wbank_d = wbank_q;
    wcol_d  = wcol_q;
    rbank_d = rbank_q;
    rcol_d  = rcol_q;
    if (wr_en) begin
      wcol_d = wcol_q + 2'd1;
      if (wcol_q == 2'd0) final_d[wbank_q] = in_final;
      if (wcol_q == 2'd3) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end
    // A bank being written is never full, so this clear never collides with the set above.
    if (rd_take) begin
      rcol_d = rcol_q + 2'd1;
      if (rcol_q == 2'd3) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= '0;
      final_q <= '0;
      wbank_q <= 1'b0;
      wcol_q  <= '0;
      rbank_q <= 1'b0;
      rcol_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      full_q  <= full_d;
      final_q <= final_d;
      wbank_q <= wbank_d;
      wcol_q  <= wcol_d;
      rbank_q <= rbank_d;
      rcol_q  <= rcol_d;
      rdy_q   <= 1'b1;
    end
  end

  // Block data needs no reset: the full flags gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) bank_q[wbank_q][wcol_q] <= in_col;
  end

  if (OUT_REG) begin : g_oreg
    logic       ov_q;
    col_t       oc_q;
    logic [1:0] oi_q;
    logic       of_q;
    logic       o_adv;

    assign o_adv   = ~ov_q | out_ready;
    assign rd_take = rd_avail & o_adv;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ov_q <= 1'b0;
        oc_q <= '0;
        oi_q <= '0;
        of_q <= 1'b0;
      end else if (o_adv) begin
        ov_q <= rd_avail;
        if (rd_avail) begin
          oc_q <= rd_col;
          oi_q <= rcol_q;
          of_q <= rd_final;
        end
      end
    end

    assign out_valid = ov_q;
    assign out_col   = oc_q;
    assign out_idx   = oi_q;
    assign out_final = of_q;
  end else begin : g_ocomb
    assign rd_take   = rd_avail & out_ready;
    assign out_valid = rd_avail;
    // Gated so the idle output reads as zero rather than stale bank contents.
    assign out_col   = rd_avail ? rd_col : '0;
    assign out_idx   = rd_avail ? rcol_q : '0;
    assign out_final = rd_avail & rd_final;
  end

endmodule

// File: tb/tb_aes_shiftmix_col32.sv
module tb_aes_shiftmix_col32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_col = '0;
  logic        in_final = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_col;
  logic [1:0]  out_idx;
  logic        out_final;

  always #5 clk = ~clk;

  aes_shiftmix_col32 #(.OUT_REG(1'b1), .MIX_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_col    (in_col),
    .in_final  (in_final),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_idx   (out_idx),
    .out_final (out_final)
  );

  typedef struct packed {
    logic [31:0] col;
    logic [1:0]  idx;
    logic        fin;
  } exp_t;

  // Block 0: FIPS-197 round 1. Block 1: MixColumns corner columns after ShiftRows.
  logic [31:0] vin  [2][4] = '{'{32'hd42711ae, 32'he0bf98f1, 32'hb8b45de5, 32'h1e415230},
                               '{32'hdbc6015c, 32'hf213c601, 32'h010a53c6, 32'hc6012245}};
  logic [31:0] vmix [2][4] = '{'{32'h046681e5, 32'he0cb199a, 32'h48f8d37a, 32'h2806264c},
                               '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6}};
  logic [31:0] vshf [2][4] = '{'{32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5},
                               '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6}};

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          out_cnt = 0;
  int          out_cyc [64];
  int          acc_cnt = 0;
  int          stall_cnt = 0;
  int          first_stall_acc = -1;
  logic        held_v = 1'b0;
  logic [31:0] held_col = '0;
  logic [1:0]  held_idx = '0;
  logic        held_fin = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: mid-cycle sampling; inputs only change 1 time unit after a rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (held_v) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_col", out_col, held_col);
        chk("hold_idx", 32'(out_idx), 32'(held_idx));
        chk("hold_final", 32'(out_final), 32'(held_fin));
      end
      held_v   = out_valid & ~out_ready;
      held_col = out_col;
      held_idx = out_idx;
      held_fin = out_final;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got col %h idx %0d, expected no output", out_col, out_idx);
        end else begin
          e = sb_q.pop_front();
          chk("out_col", out_col, e.col);
          chk("out_idx", 32'(out_idx), 32'(e.idx));
          chk("out_final", 32'(out_final), 32'(e.fin));
        end
        if (out_cnt < 64) out_cyc[out_cnt] = cyc;
        out_cnt++;
      end
    end
  end

  task automatic send_col(input logic [31:0] c, input logic f);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    in_valid = 1'b1;
    in_col   = c;
    in_final = f;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) begin
        stall_cnt++;
        if (first_stall_acc < 0) first_stall_acc = acc_cnt;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 for %0d cycles, expected an accept", n);
    end else begin
      acc_cnt++;
    end
  endtask

  // Expected values are queued as the block is issued; in_final is toggled on
  // columns 1..3 because the stage must ignore it there.
  task automatic send_block(input int b, input logic f);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.col = f ? vshf[b][i] : vmix[b][i];
      e.idx = 2'(i);
      e.fin = f;
      sb_q.push_back(e);
    end
    for (int i = 0; i < 4; i++) send_col(vin[b][i], (i == 0) ? f : ~f);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_col", out_col, 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_final", 32'(out_final), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rdy_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rdy_after_edge", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // FIPS-197 round 1 with MixColumns, plus first-block latency.
    send_block(0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_T", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency_T1", 32'(out_valid), 32'd1);
    wait_drain("drain_t1");

    // Final round: ShiftRows only.
    @(posedge clk); #1;
    send_block(0, 1'b1);
    in_valid = 1'b0;
    wait_drain("drain_t2");

    // Three blocks back to back at full rate.
    @(posedge clk); #1;
    base      = out_cnt;
    stall_cnt = 0;
    send_block(0, 1'b0);
    send_block(0, 1'b1);
    send_block(1, 1'b0);
    in_valid = 1'b0;
    wait_drain("drain_t3");
    chk("b2b_stalls", 32'(stall_cnt), 32'd0);
    chk("b2b_contig", 32'(out_cyc[base+11] - out_cyc[base]), 32'd11);

    // Downstream stalled for 12 cycles while 3 blocks are offered.
    @(posedge clk); #1;
    out_ready       = 1'b0;
    acc_cnt         = 0;
    first_stall_acc = -1;
    fork
      begin
        send_block(1, 1'b1);
        send_block(0, 1'b0);
        send_block(1, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (12) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain("drain_t4");
    chk("stall_after_cols", 32'(first_stall_acc), 32'd8);

    // Reset with a partial block buffered; only the new block may appear.
    @(posedge clk); #1;
    send_col(vin[0][0], 1'b1);
    send_col(vin[0][1], 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send_block(1, 1'b0);
    in_valid = 1'b0;
    wait_drain("drain_t5");

    repeat (6) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got no completion by 200000, expected finish earlier");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
